// File: rtl/x7seg_scan_if.sv
// ============================================================================
// x7seg_scan_if : valid/ready value handshake into the x7seg scan driver
// Revision 1.0
// ============================================================================
`default_nettype none

interface x7seg_scan_if;
  logic        valid;
  logic        ready;
  logic [15:0] bin;
  logic        hex_mode;

  modport master (
    output valid,
    output bin,
    output hex_mode,
    input  ready
  );

  modport slave (
    input  valid,
    input  bin,
    input  hex_mode,
    output ready
  );
endinterface

`default_nettype wire

// File: rtl/x7seg_scan.sv
// ============================================================================
// x7seg_scan : binary/BCD value capture and 4-digit multiplexed scan for x7seg
// Revision 1.0
// ============================================================================
`default_nettype none

module x7seg_scan #(
  parameter int SCAN_DIV = 100000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  x7seg_scan_if.slave     bus,
  output logic [3:0]      x,
  output logic [3:0]      an,
  output logic            ovf
);

  localparam int                DIV_W      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]        CONV_STEPS = 4'd14;
  localparam logic [15:0]       DEC_MAX    = 16'd9999;
  localparam logic [15:0]       DEC_SAT    = 16'h9999;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_CONV = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [15:0]      disp_q, disp_d;
  logic             ovf_q, ovf_d;
  logic [13:0]      shift_q, shift_d;
  logic [15:0]      bcd_q, bcd_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       x_q, x_d;
  logic [3:0]       an_q, an_d;

  logic [15:0] bcd_adj;
  logic [15:0] bcd_sh;
  logic [13:0] shift_sh;
  logic [3:0]  blank;

  assign bus.ready = (state_q == ST_IDLE);
  assign x         = x_q;
  assign an        = an_q;
  assign ovf       = ovf_q;

  // One double-dabble step: add-3 correction then shift {bcd, shift} left.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_sh   = {bcd_adj[14:0], shift_q[13]};
    shift_sh = {shift_q[12:0], 1'b0};
  end

  always_comb begin
    state_d = state_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.valid) begin
          if (bus.hex_mode) begin
            disp_d = bus.bin;
            ovf_d  = 1'b0;
          end else if (bus.bin > DEC_MAX) begin
            disp_d = DEC_SAT;
            ovf_d  = 1'b1;
          end else begin
            shift_d = bus.bin[13:0];
            bcd_d   = 16'h0000;
            cnt_d   = CONV_STEPS;
            state_d = ST_CONV;
          end
        end
      end
      ST_CONV: begin
        bcd_d   = bcd_sh;
        shift_d = shift_sh;
        cnt_d   = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          disp_d  = bcd_sh;
          ovf_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Leading-zero blanking: a digit blanks only if it and all higher digits are 0.
  always_comb begin
    blank    = 4'b0000;
    blank[3] = BLANK_LZ && (disp_q[15:12] == 4'h0);
    blank[2] = blank[3] && (disp_q[11:8] == 4'h0);
    blank[1] = blank[2] && (disp_q[7:4] == 4'h0);
  end

  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    idx_d     = idx_q;
    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
      idx_d     = idx_q + 2'd1;
    end
    x_d  = disp_q[{idx_q, 2'b00} +: 4];
    an_d = blank[idx_q] ? 4'b1111 : ~(4'b0001 << idx_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      disp_q    <= 16'h0000;
      ovf_q     <= 1'b0;
      shift_q   <= 14'h0000;
      bcd_q     <= 16'h0000;
      cnt_q     <= 4'd0;
      div_cnt_q <= '0;
      idx_q     <= 2'd0;
      x_q       <= 4'h0;
      an_q      <= 4'b1110;
    end else begin
      state_q   <= state_d;
      disp_q    <= disp_d;
      ovf_q     <= ovf_d;
      shift_q   <= shift_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      x_q       <= x_d;
      an_q      <= an_d;
    end
  end

endmodule

`default_nettype wire
